prince_bwd_rounds: RTL

Iterative engine for the backward half of the PRINCE core. It consumes the 64-bit state after the middle layer (S, M', S⁻¹) and applies backward rounds 6..10, one per clock. Each round is a k1/RC addition, then the M⁻¹ layer (our existing inverse linear layer), then the inverse S-box layer. It finishes with the RC11 ⊕ k1 whitening. The block sits between the middle-layer stage and the k0′ output whitening, with valid/ready handshakes on both sides.

---
 rtl/prince_bwd_rounds.sv | 128 ++++++++++++
 1 files changed

// File: rtl/prince_bwd_rounds.sv
// PRINCE backward half: rounds 6..10 applied iteratively, one per clock, then
// RC11 ^ k1 whitening. Valid/ready on both sides; no overlap between blocks.

module prince_sinv_nib (
    input  logic [3:0] x,
    output logic [3:0] y
);
    always_comb begin
        case (x)
            4'h0: y = 4'hb;  4'h1: y = 4'h7;  4'h2: y = 4'h3;  4'h3: y = 4'h2;
            4'h4: y = 4'hf;  4'h5: y = 4'hd;  4'h6: y = 4'h8;  4'h7: y = 4'h9;
            4'h8: y = 4'ha;  4'h9: y = 4'h6;  4'ha: y = 4'h4;  4'hb: y = 4'h0;
            4'hc: y = 4'h5;  4'hd: y = 4'he;  4'he: y = 4'hc;  default: y = 4'h1;
        endcase
    end
endmodule

module prince_bwd_rounds (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [63:0] data_in,
    input  logic [63:0] k1,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [63:0] data_out
);
    localparam logic [63:0] RC6  = 64'h7ef84f78fd955cb1;
    localparam logic [63:0] RC7  = 64'h85840851f1ac43aa;
    localparam logic [63:0] RC8  = 64'hc882d32f25323c54;
    localparam logic [63:0] RC9  = 64'h64a51195e0e3610d;
    localparam logic [63:0] RC10 = 64'hd3b5a399ca0c2399;
    localparam logic [63:0] RC11 = 64'hc0ac29b7c97c50dd;

    // Nibble positions counted from the most significant nibble (AES-style grid).
    localparam int SR_INV [16] = '{0, 13, 10, 7, 4, 1, 14, 11, 8, 5, 2, 15, 12, 9, 6, 3};

    typedef enum logic [1:0] {IDLE, RUN, DONE} fsm_t;

    fsm_t             fsm_q, fsm_d;
    logic [63:0]      state_q, key_q;
    logic [2:0]       rnd_q;
    logic [63:0]      rc, t, u, v;
    logic [15:0][3:0] u_nib, v_nib;

    function automatic logic [63:0] inv_shift_rows(input logic [63:0] x);
        logic [15:0][3:0] xn, yn;
        xn = x;
        for (int i = 0; i < 16; i++)
            yn[15 - i] = xn[15 - SR_INV[i]];
        return yn;
    endfunction

    // M' = diag(M0^, M1^, M1^, M0^); each 4x4 sub-block M_i is identity with
    // bit i (MSB-first) removed, and block (a,b) uses M_{(a+b+off) mod 4}.
    function automatic logic [63:0] m_prime(input logic [63:0] x);
        logic [15:0][3:0] xn, yn;
        int sel;
        xn = x;
        yn = '0;
        for (int c = 0; c < 4; c++)
            for (int a = 0; a < 4; a++)
                for (int b = 0; b < 4; b++) begin
                    sel = (a + b + ((c == 1 || c == 2) ? 1 : 0)) % 4;
                    yn[15 - 4*c - a] ^= xn[15 - 4*c - b] & ~(4'b1000 >> sel);
                end
        return yn;
    endfunction

    always_comb begin
        case (rnd_q)
            3'd0:    rc = RC6;
            3'd1:    rc = RC7;
            3'd2:    rc = RC8;
            3'd3:    rc = RC9;
            3'd4:    rc = RC10;
            default: rc = '0;
        endcase
    end

    assign t     = state_q ^ key_q ^ rc;
    assign u     = m_prime(inv_shift_rows(t));
    assign u_nib = u;

    for (genvar n = 0; n < 16; n++) begin : g_sinv
        prince_sinv_nib u_sinv (.x(u_nib[n]), .y(v_nib[n]));
    end
    assign v = v_nib;

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            IDLE:    if (in_valid)      fsm_d = RUN;
            RUN:     if (rnd_q == 3'd4) fsm_d = DONE;
            DONE:    if (out_ready)     fsm_d = IDLE;
            default:                    fsm_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q   <= IDLE;
            state_q <= '0;
            key_q   <= '0;
            rnd_q   <= '0;
        end else begin
            fsm_q <= fsm_d;
            case (fsm_q)
                IDLE: if (in_valid) begin
                    state_q <= data_in;
                    key_q   <= k1;
                    rnd_q   <= '0;
                end
                RUN: begin
                    state_q <= v;
                    rnd_q   <= (rnd_q == 3'd4) ? 3'd0 : rnd_q + 3'd1;
                end
                default: ;
            endcase
        end
    end

    // Outputs decode registered state only, so reset clears them immediately.
    assign in_ready  = (fsm_q == IDLE);
    assign out_valid = (fsm_q == DONE);
    assign data_out  = out_valid ? (state_q ^ key_q ^ RC11) : '0;
endmodule
